// File: rtl/ram_model_pkg.sv
// ram_model_pkg: shared types and helpers for the 1RW1R byte-write RAM model
// Provides the clear-sequencer state enum and the address-width helper.
package ram_model_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    // Address width for a given depth; never narrower than one bit.
    function automatic int calc_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset zero-fill sequencer for the RAM model
// Ports: CLK, resetn (sync, active-low) in; busy high while filling,
// clr_we/clr_addr drive the array write port during the fill.
module ram_clear_seq
    import ram_model_pkg::*;
#(
    parameter int WORDS          = 256,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = 8
) (
    input  logic          CLK,
    input  logic          resetn,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The edge that clears the last word also leaves CLEAR.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == CLEAR) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt == AW'(WORDS - 1)) ? READY : CLEAR;
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_1rw1r_bw.sv
// ram_1rw1r_bw: behavioural 1RW1R SRAM with byte writes, bypass and zero-fill
// Ports: CLK, resetn (sync, active-low); port 0 EN0/WE0/A0/Di0 -> Do0 (read/write);
// port 1 EN1/A1 -> Do1 (read-only); BUSY high during the post-reset zero-fill.
module ram_1rw1r_bw
    import ram_model_pkg::*;
#(
    parameter  int WORDS          = 256,
    parameter  int WSIZE          = 4,
    parameter  int OUT_REG        = 0,
    parameter  int BYPASS         = 1,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int DW             = 8 * WSIZE,
    localparam int AW             = calc_aw(WORDS)
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             EN0,
    input  logic [WSIZE-1:0] WE0,
    input  logic [AW-1:0]    A0,
    input  logic [DW-1:0]    Di0,
    output logic [DW-1:0]    Do0,
    input  logic             EN1,
    input  logic [AW-1:0]    A1,
    output logic [DW-1:0]    Do1,
    output logic             BUSY
);

    localparam logic [AW:0] LIM = (AW + 1)'(WORDS);

    logic [DW-1:0]    mem [WORDS];
    logic             busy, clr_we;
    logic [AW-1:0]    clr_addr, wa;
    logic [WSIZE-1:0] wl;
    logic [DW-1:0]    wd, rd0, rd1, byp, s0, s1;
    logic             ok0, ok1;

    ram_clear_seq #(
        .WORDS         (WORDS),
        .CLEAR_ON_RESET(CLEAR_ON_RESET),
        .AW            (AW)
    ) u_seq (
        .CLK     (CLK),
        .resetn  (resetn),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign BUSY = busy;
    assign ok0  = {1'b0, A0} < LIM;
    assign ok1  = {1'b0, A1} < LIM;

    // The zero-fill takes over the port-0 write path while it runs.
    assign wa = clr_we ? clr_addr : A0;
    assign wl = clr_we ? '1 : ((EN0 && ok0) ? WE0 : '0);
    assign wd = clr_we ? '0 : Di0;

    always_ff @(posedge CLK) begin
        if (resetn)
            for (int i = 0; i < WSIZE; i++)
                if (wl[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
    end

    // Out-of-range reads return zero rather than indexing past the array.
    assign rd0 = ok0 ? mem[A0] : '0;
    assign rd1 = ok1 ? mem[A1] : '0;

    always_comb begin
        byp = rd1;
        for (int i = 0; i < WSIZE; i++)
            if (BYPASS != 0 && EN0 && ok1 && A0 == A1 && WE0[i])
                byp[8*i +: 8] = Di0[8*i +: 8];
    end

    always_ff @(posedge CLK) begin
        if (!resetn || busy) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= EN0 ? rd0 : '0;
            s1 <= EN1 ? byp : '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] q0, q1;
            always_ff @(posedge CLK) begin
                if (!resetn) begin
                    q0 <= '0;
                    q1 <= '0;
                end else begin
                    q0 <= s0;
                    q1 <= s1;
                end
            end
            assign Do0 = q0;
            assign Do1 = q1;
        end else begin : g_direct
            assign Do0 = s0;
            assign Do1 = s1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_1rw1r_bw.sv
// tb_ram_1rw1r_bw: self-checking bench for two RAM configurations sharing stimulus
module tb_ram_1rw1r_bw;

    logic        CLK = 1'b0, resetn = 1'b0, EN0 = 1'b0, EN1 = 1'b0;
    logic [3:0]  WE0 = '0;
    logic [7:0]  A0 = '0, A1 = '0;
    logic [31:0] Di0 = '0;
    logic [31:0] Do0a, Do1a, Do0b, Do1b;
    logic        busya, busyb;
    int          n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    ram_1rw1r_bw dut_a (
        .CLK(CLK), .resetn(resetn), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0a),
        .EN1(EN1), .A1(A1), .Do1(Do1a), .BUSY(busya)
    );

    ram_1rw1r_bw #(.WORDS(200), .OUT_REG(1), .BYPASS(0)) dut_b (
        .CLK(CLK), .resetn(resetn), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0b),
        .EN1(EN1), .A1(A1), .Do1(Do1b), .BUSY(busyb)
    );

    // Reference model: index 0 = default instance, index 1 = 200-word, registered, no bypass.
    logic [31:0] m [2][256];
    int          w [2] = '{256, 200};
    int          bp [2] = '{1, 0};
    int          bl [2] = '{0, 0};
    logic [31:0] e0 [2], e1 [2];
    logic [31:0] st0 = '0, st1 = '0;

    function automatic logic [31:0] rd(input int k, input logic [7:0] a);
        return (int'(a) < w[k]) ? m[k][a] : 32'h0;
    endfunction

    function automatic logic [31:0] p1(input int k);
        logic [31:0] v = rd(k, A1);
        if (bp[k] != 0 && EN0 && A0 == A1 && int'(A1) < w[k])
            for (int i = 0; i < 4; i++) if (WE0[i]) v[8*i +: 8] = Di0[8*i +: 8];
        return v;
    endfunction

    task automatic cycle();
        logic [31:0] n0, n1;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            n0 = '0;
            n1 = '0;
            if (!resetn) bl[k] = w[k];
            else if (bl[k] > 0) begin
                bl[k]--;
                if (bl[k] == 0) for (int j = 0; j < w[k]; j++) m[k][j] = '0;
            end else begin
                n0 = EN0 ? rd(k, A0) : 32'h0;
                n1 = EN1 ? p1(k) : 32'h0;
                if (EN0 && int'(A0) < w[k])
                    for (int i = 0; i < 4; i++) if (WE0[i]) m[k][A0][8*i +: 8] = Di0[8*i +: 8];
            end
            if (k == 0) begin
                e0[0] = n0;
                e1[0] = n1;
            end else begin
                e0[1] = resetn ? st0 : 32'h0;
                e1[1] = resetn ? st1 : 32'h0;
                st0 = n0;
                st1 = n1;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        EN0 = 0; EN1 = 0; WE0 = '0;
    endtask

    task automatic test_reset();
        int ca = 0, cb = 0;
        resetn = 0; EN0 = 1; WE0 = 4'hF; A0 = 8'd1; Di0 = 32'h5A5A5A5A;
        cycle(); cycle();
        n_chk++; if (Do0a !== 32'h0 || Do1a !== 32'h0) begin n_fail++; $display("FAIL reset_do_a got %h/%h exp 0/0", Do0a, Do1a); end
        n_chk++; if (Do0b !== 32'h0 || Do1b !== 32'h0) begin n_fail++; $display("FAIL reset_do_b got %h/%h exp 0/0", Do0b, Do1b); end
        n_chk++; if (busya !== 1'b1 || busyb !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b/%b exp 1/1", busya, busyb); end
        resetn = 1;
        for (int i = 0; i < 260; i++) begin
            if (i < 190) begin
                EN0 = 1; WE0 = 4'hF; A0 = 8'($urandom); Di0 = $urandom; EN1 = 1; A1 = 8'($urandom);
            end else set_idle();
            if (busya) ca++;
            if (busyb) cb++;
            cycle();
            n_chk++; if (Do0a !== e0[0] || Do1a !== e1[0]) begin n_fail++; $display("FAIL clear_do_a got %h/%h exp %h/%h", Do0a, Do1a, e0[0], e1[0]); end
        end
        n_chk++; if (ca != 256) begin n_fail++; $display("FAIL busy_len_a got %0d exp 256", ca); end
        n_chk++; if (cb != 200) begin n_fail++; $display("FAIL busy_len_b got %0d exp 200", cb); end
        n_chk++; if (busya !== 1'b0 || busyb !== 1'b0) begin n_fail++; $display("FAIL busy_end got %b/%b exp 0/0", busya, busyb); end
        foreach (w[k]) begin end
        for (int j = 0; j < 3; j++) begin
            EN0 = 1; WE0 = '0; EN1 = 1; A0 = 8'(j * 128 - (j == 2 ? 1 : 0)); A1 = A0;
            cycle();
            n_chk++; if (Do0a !== 32'h0 || Do1a !== 32'h0) begin n_fail++; $display("FAIL zero_read a=%0d got %h/%h exp 0/0", A0, Do0a, Do1a); end
        end
        set_idle(); cycle(); cycle();
    endtask

    task automatic test_byte_lanes();
        EN0 = 1; A0 = 8'd5; WE0 = 4'hF; Di0 = 32'hDEADBEEF; cycle();
        WE0 = 4'b0101; Di0 = 32'h11223344; cycle();
        WE0 = '0; cycle();
        n_chk++; if (Do0a !== 32'hDE22BE44) begin n_fail++; $display("FAIL lanes_a got %h exp DE22BE44", Do0a); end
        set_idle(); cycle();
        n_chk++; if (Do0b !== 32'hDE22BE44) begin n_fail++; $display("FAIL lanes_b got %h exp DE22BE44", Do0b); end
        n_chk++; if (Do0a !== 32'h0) begin n_fail++; $display("FAIL lanes_dis_a got %h exp 0", Do0a); end
    endtask

    task automatic test_latency();
        EN0 = 1; A0 = 8'd9; WE0 = 4'hF; Di0 = 32'hCAFEF00D; cycle();
        n_chk++; if (Do0a !== 32'h0) begin n_fail++; $display("FAIL rbw_a got %h exp 0", Do0a); end
        set_idle(); cycle();
        n_chk++; if (Do0b !== 32'h0) begin n_fail++; $display("FAIL rbw_b got %h exp 0", Do0b); end
        EN0 = 1; WE0 = '0; cycle();
        n_chk++; if (Do0a !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat1_a got %h exp CAFEF00D", Do0a); end
        n_chk++; if (Do0b !== 32'h0) begin n_fail++; $display("FAIL lat2_early_b got %h exp 0", Do0b); end
        set_idle(); cycle();
        n_chk++; if (Do0b !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat2_b got %h exp CAFEF00D", Do0b); end
    endtask

    task automatic test_bypass();
        EN0 = 1; A0 = 8'd3; WE0 = 4'hF; Di0 = 32'hAAAAAAAA; cycle();
        WE0 = 4'b0011; Di0 = 32'h12345678; EN1 = 1; A1 = 8'd3; cycle();
        n_chk++; if (Do1a !== 32'hAAAA5678) begin n_fail++; $display("FAIL bypass_a got %h exp AAAA5678", Do1a); end
        n_chk++; if (Do0a !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL bypass_do0_a got %h exp AAAAAAAA", Do0a); end
        set_idle(); cycle();
        n_chk++; if (Do1b !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL nobypass_b got %h exp AAAAAAAA", Do1b); end
    endtask

    task automatic test_out_of_range();
        EN0 = 1; A0 = 8'd210; WE0 = 4'hF; Di0 = 32'h55555555; cycle();
        set_idle(); EN1 = 1; A1 = 8'd210; cycle();
        n_chk++; if (Do1a !== 32'h55555555) begin n_fail++; $display("FAIL inrange_a got %h exp 55555555", Do1a); end
        set_idle(); cycle();
        n_chk++; if (Do1b !== 32'h0) begin n_fail++; $display("FAIL oor_b got %h exp 0", Do1b); end
        EN0 = 1; A0 = 8'd199; WE0 = 4'hF; Di0 = 32'h0BADCAFE; cycle();
        set_idle(); EN1 = 1; A1 = 8'd199; cycle();
        set_idle(); cycle();
        n_chk++; if (Do1b !== 32'h0BADCAFE) begin n_fail++; $display("FAIL last_word_b got %h exp 0BADCAFE", Do1b); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            EN0 = 1'($urandom); EN1 = 1'($urandom); WE0 = 4'($urandom);
            A0 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            A1 = ($urandom_range(0, 1) != 0) ? A0 : 8'($urandom_range(0, 7));
            Di0 = $urandom;
            cycle();
            n_chk++; if (Do0a !== e0[0] || Do1a !== e1[0]) begin n_fail++; $display("FAIL rand_a got %h/%h exp %h/%h", Do0a, Do1a, e0[0], e1[0]); end
            n_chk++; if (Do0b !== e0[1] || Do1b !== e1[1]) begin n_fail++; $display("FAIL rand_b got %h/%h exp %h/%h", Do0b, Do1b, e0[1], e1[1]); end
            n_chk++; if (busya !== (bl[0] > 0) || busyb !== (bl[1] > 0)) begin n_fail++; $display("FAIL rand_busy got %b/%b exp %b/%b", busya, busyb, bl[0] > 0, bl[1] > 0); end
        end
        set_idle(); cycle(); cycle();
    endtask

    task automatic test_reset_mid_clear();
        int ca = 0;
        resetn = 0; cycle(); resetn = 1;
        for (int i = 0; i < 100; i++) begin
            EN0 = 1; WE0 = 4'hF; A0 = 8'(i); Di0 = $urandom; cycle();
        end
        n_chk++; if (busya !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busya); end
        resetn = 0; cycle(); resetn = 1;
        for (int i = 0; i < 270; i++) begin
            if (i < 190) begin
                EN0 = 1; WE0 = 4'hF; A0 = 8'($urandom_range(0, 99)); Di0 = $urandom;
            end else set_idle();
            if (busya) ca++;
            cycle();
        end
        n_chk++; if (ca != 256) begin n_fail++; $display("FAIL mid_busy_len got %0d exp 256", ca); end
        for (int j = 0; j < 3; j++) begin
            EN0 = 1; WE0 = '0; EN1 = 1; A0 = 8'(j * 49); A1 = A0; cycle();
            n_chk++; if (Do0a !== 32'h0 || Do1a !== 32'h0) begin n_fail++; $display("FAIL masked_write a=%0d got %h/%h exp 0/0", A0, Do0a, Do1a); end
        end
        set_idle(); cycle(); cycle();
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_latency();
        test_bypass();
        test_out_of_range();
        test_random(400);
        test_reset_mid_clear();
        test_random(200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_1rw1r_bw.md
Name: ram_1rw1r_bw

Overview:
- Parametrised behavioural SRAM model for the management SoC DV environment.
- Next generation of the single-port byte-write RAM model, with these additions:
  - configurable depth and width;
  - a second read-only port;
  - optional write-to-read bypass;
  - optional output pipeline register;
  - a hardware zero-fill sequence after reset, flagged by BUSY.
- Instantiated by testbenches in place of DFFRAM-style macros (1RW1R organisation).

Parameters:
- WORDS, 256: number of words; need not be a power of two.
- WSIZE, 4: bytes per word; data width DW = 8*WSIZE.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- BYPASS, 1: 1 forwards same-cycle port-0 write data to port-1 reads of the same address.
- CLEAR_ON_RESET, 1: 1 zero-fills the whole array after reset; 0 leaves contents untouched (X in simulation).

Ports:
- CLK  in  1  clock; all activity on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- EN0  in  1  port-0 enable.
- WE0  in  WSIZE  port-0 byte write enables.
- A0  in  AW  port-0 address; AW = max(1, clog2(WORDS)).
- Di0  in  DW  port-0 write data.
- Do0  out  DW  port-0 read data.
- EN1  in  1  port-1 (read-only) enable.
- A1  in  AW  port-1 address.
- Do1  out  DW  port-1 read data.
- BUSY  out  1  high while the zero-fill is in progress; ports are ignored while it is high.

Behaviour:
- Reset: a rising edge with resetn=0 sets:
  - Do0, Do1 and any pipeline registers to 0;
  - clear counter to 0;
  - state to CLEAR if CLEAR_ON_RESET=1, else READY;
  - BUSY to 1 if CLEAR_ON_RESET=1, else 0.
- Array contents are not altered by reset itself.
- State machine: two states, CLEAR and READY.
  - CLEAR:
    - Each edge writes 0 to word[cnt], then cnt increments.
    - On the edge that clears word WORDS-1, state becomes READY and BUSY becomes 0.
    - BUSY is therefore high for exactly WORDS cycles after reset is released.
    - Do0 and Do1 are held at 0; EN/WE/A/Di inputs are ignored.
  - Reset asserted during CLEAR restarts the sequence from word 0.
  - READY stays in READY until the next reset.
- Port 0, READY state, with OUT_REG=0:
  - EN0=1: Do0 <= word[A0] (old contents, read-before-write). For each lane i with WE0[i]=1, byte i of word[A0] <= Di0[8i+7:8i].
  - EN0=0: Do0 <= 0; no write.
- Port 1, READY state:
  - EN1=1: Do1 <= word[A1].
  - EN1=0: Do1 <= 0.
  - If BYPASS=1 and EN0=1 and A0==A1 in the same cycle: each lane with WE0[i]=1 returns Di0 byte i; other lanes return the stored byte.
  - If BYPASS=0: port 1 returns the old data.
- OUT_REG=1: the latency-1 values above pass through one further register, so Do0/Do1 appear one cycle later. The zero-on-disable rule applies at the first stage.
- Out-of-range address (A >= WORDS): read returns 0, write is dropped, no X propagation.
- EN0=1 with WE0=0: pure read.
- Both ports reading the same address with no write: identical data.
- X or Z on EN/WE while BUSY=0: model may flag with $display; not functionally defined.

Decomposition:
- Package ram_model_pkg holds:
  - state enum {CLEAR, READY};
  - an AW-calculation function (clog2 with minimum 1).
- Sub-module ram_clear_seq holds:
  - the CLEAR/READY FSM, counter and BUSY generation;
  - outputs clr_we and clr_addr, which the array wrapper muxes over port 0.
- Array, byte-lane write logic, bypass merge and output pipeline stay in the top module.

Test Plan:
- Reset with defaults, resetn low 2 cycles then high:
  - BUSY high for exactly 256 cycles, then low.
  - Afterwards, reads of A0=0, 128 and 255 return 0x00000000.
- Byte lanes: write 0xDEADBEEF to A0=5 with WE0=4'hF, then 0x11223344 with WE0=4'b0101 → read of 5 returns 0xDE22BE44.
- Latency and read-before-write:
  - Same-cycle write 0xCAFEF00D plus read at A0=9 → Do0 shows prior contents.
  - Next read shows 0xCAFEF00D 1 cycle after EN0 (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- Bypass with word 3 holding 0xAAAAAAAA:
  - EN0=1, WE0=4'b0011, Di0=0x12345678, A0=A1=3 → Do1 = 0xAAAA5678 with BYPASS=1, 0xAAAAAAAA with BYPASS=0.
- Reset mid-clear and port masking:
  - Assert resetn low at cycle 100 of CLEAR → BUSY stays high 256 further cycles after release.
  - Writes issued while BUSY=1 do not persist.
- WORDS=200 (AW=8) → write to A0=210 dropped; read of A1=210 returns 0; word 199 read/write works.
